// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte path: case-conversion mode codes,
// ASCII letter bounds and the conversion function used by the RX-side buffer.
package uart_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_UPPER = 2'b01,
    MODE_LOWER = 2'b10,
    MODE_SWAP  = 2'b11
  } mode_e;

  localparam logic [7:0] ASCII_UP_LO = 8'h41;  // 'A'
  localparam logic [7:0] ASCII_UP_HI = 8'h5A;  // 'Z'
  localparam logic [7:0] ASCII_LO_LO = 8'h61;  // 'a'
  localparam logic [7:0] ASCII_LO_HI = 8'h7A;  // 'z'
  localparam logic [7:0] CASE_DELTA  = 8'h20;

  // Letters move between cases by the fixed ASCII offset; everything else,
  // including the upper half of the byte range, is returned untouched.
  function automatic logic [7:0] ascii_case(input logic [7:0] b, input mode_e mode);
    logic       is_upper;
    logic       is_lower;
    logic [7:0] r;
    is_upper = (b >= ASCII_UP_LO) && (b <= ASCII_UP_HI);
    is_lower = (b >= ASCII_LO_LO) && (b <= ASCII_LO_HI);
    r        = b;
    case (mode)
      MODE_UPPER: if (is_lower) r = b - CASE_DELTA;
      MODE_LOWER: if (is_upper) r = b + CASE_DELTA;
      MODE_SWAP: begin
        if (is_lower)      r = b - CASE_DELTA;
        else if (is_upper) r = b + CASE_DELTA;
      end
      default: r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is visible on
// o_rd_data whenever o_empty is low; o_rd_data reads as zero while empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_fire;
  logic             rd_fire;

  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_level = wr_ptr_q - rd_ptr_q;

  // A write into a full FIFO is only legal when the head leaves on the same
  // edge; in that case the write lands in the slot being vacated.
  assign wr_fire = i_wr_en && (!o_full || i_rd_en);
  assign rd_fire = i_rd_en && !o_empty;

  // Head of queue presented combinationally; zero while nothing is stored.
  always_comb begin
    o_rd_data = '0;
    if (!o_empty) o_rd_data = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer advance, wrapping naturally through the extra MSB.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + LW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + LW'(1);
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since empty masks the output.
  always_ff @(posedge i_clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/case_conv_buffer.sv
// Sits between the UART receiver and transmitter. Each received byte is
// case-converted, registered in a one-entry stage, then written into a FWFT
// FIFO that feeds the transmitter over valid/ready.
//
// Handshake: the receive side is a 1-cycle strobe with no backpressure. The
// transmit side transfers a byte on every clock edge where o_valid and i_ready
// are both high; o_valid stays high and o_data stays stable until that edge,
// and i_ready is ignored while o_valid is low.
//
// Bytes arriving while the FIFO is full (and not popping) are dropped and
// recorded in a sticky flag plus a saturating counter.
module case_conv_buffer
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int CNT_W = 8,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_data,
  input  logic             i_valid,
  input  logic [1:0]       i_mode,
  input  logic             i_clr_ovf,
  output logic [7:0]       o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [LW-1:0]    o_level,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_drop_cnt
);

  logic [7:0]       conv_byte;
  logic [7:0]       stage_q, stage_d;
  logic             stage_vld_q, stage_vld_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             wr_en;
  logic             drop;

  assign conv_byte = ascii_case(i_data, mode_e'(i_mode));

  assign pop   = !fifo_empty && i_ready;
  assign wr_en = stage_vld_q && (!fifo_full || pop);
  assign drop  = stage_vld_q && fifo_full && !pop;

  // Stage register: reloads on every strobe, so back-to-back strobes keep it
  // valid and the FIFO sees one write per cycle.
  always_comb begin
    stage_vld_d = i_valid;
    stage_d     = stage_q;
    if (i_valid) stage_d = conv_byte;
  end

  // Overflow bookkeeping; a drop on the same edge as a clear still counts.
  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (i_clr_ovf) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (cnt_d != {CNT_W{1'b1}}) cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // Stage and overflow state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (wr_en),
    .i_wr_data (stage_q),
    .i_rd_en   (pop),
    .o_rd_data (o_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_level   (o_level)
  );

  assign o_valid    = !fifo_empty;
  assign o_overflow = ovf_q;
  assign o_drop_cnt = cnt_q;

endmodule

// File: tb/tb_case_conv_buffer.sv
// Bench for case_conv_buffer: a driver advances one clock per call and
// updates an occupancy/flag model; a negedge monitor checks every presented
// byte against an expected queue and the status outputs against the model.
module tb_case_conv_buffer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic [7:0]       i_data = '0;
  logic             i_valid = 1'b0;
  logic [1:0]       i_mode = '0;
  logic             i_clr_ovf = 1'b0;
  logic             i_ready = 1'b0;
  logic [7:0]       o_data;
  logic             o_valid;
  logic [LW-1:0]    o_level;
  logic             o_overflow;
  logic [CNT_W-1:0] o_drop_cnt;

  case_conv_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_mode     (i_mode),
    .i_clr_ovf  (i_clr_ovf),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_level    (o_level),
    .o_overflow (o_overflow),
    .o_drop_cnt (o_drop_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish (got running, expected done)");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  int         m_level = 0;
  bit         m_ovf = 0;
  int         m_cnt = 0;
  bit         st_pend = 0;
  logic [7:0] st_byte = '0;
  bit         mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion from the ASCII rules.
  function automatic logic [7:0] ref_conv(input logic [7:0] b, input logic [1:0] m);
    int x;
    bit up;
    bit lo;
    x  = int'(b);
    up = (m == 2'd1) || (m == 2'd3);
    lo = (m == 2'd2) || (m == 2'd3);
    if (up && x >= 97 && x <= 122) return 8'(x - 32);
    if (lo && x >= 65 && x <= 90)  return 8'(x + 32);
    return b;
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; applies inputs, predicts the next edge,
  // waits for it and commits the prediction.
  task automatic step(input bit v, input logic [7:0] d, input logic [1:0] m,
                      input bit r, input bit c);
    bit pop;
    bit wr;
    bit drop;
    int n_level;
    bit n_ovf;
    int n_cnt;
    i_valid = v; i_data = d; i_mode = m; i_ready = r; i_clr_ovf = c;
    pop  = (m_level > 0) && r;
    wr   = 0;
    drop = 0;
    if (st_pend) begin
      if (m_level < DEPTH || pop) begin
        wr = 1;
        exp_q.push_back(st_byte);
      end else begin
        drop = 1;
      end
    end
    n_level = m_level + (wr ? 1 : 0) - (pop ? 1 : 0);
    n_ovf = m_ovf;
    n_cnt = m_cnt;
    if (c) begin n_ovf = 0; n_cnt = 0; end
    if (drop) begin
      n_ovf = 1;
      n_cnt = (n_cnt == CNT_MAX) ? CNT_MAX : n_cnt + 1;
    end
    @(posedge i_clk); #1;
    m_level = n_level; m_ovf = n_ovf; m_cnt = n_cnt;
    st_pend = v;
    st_byte = ref_conv(d, m);
    i_valid = 0; i_clr_ovf = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_level > 0 || st_pend) && n < 200) begin
      step(0, 8'h00, 2'd0, 1, 0);
      n++;
    end
    check("drain_exp_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    i_valid = 0; i_ready = 0; i_clr_ovf = 0;
    #1 i_rst = 1;
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_level", 32'(o_level), 32'd0);
    check("rst_o_data", 32'(o_data), 32'd0);
    check("rst_o_overflow", 32'(o_overflow), 32'd0);
    check("rst_o_drop_cnt", 32'(o_drop_cnt), 32'd0);
    exp_q.delete();
    m_level = 0; m_ovf = 0; m_cnt = 0; st_pend = 0;
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst = 0;
  endtask

  task automatic check_log(input string nm, input logic [7:0] e[$]);
    check({nm, "_count"}, 32'(rx_log.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < rx_log.size(); i++)
      check(nm, 32'(rx_log[i]), 32'(e[i]));
  endtask

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    if (mon_en && !i_rst) begin
      check("o_valid", 32'(o_valid), 32'(m_level > 0));
      check("o_level", 32'(o_level), 32'(m_level));
      check("o_overflow", 32'(o_overflow), 32'(m_ovf));
      check("o_drop_cnt", 32'(o_drop_cnt), 32'(m_cnt));
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL o_data_unexpected: got %0h expected no byte at %0t", o_data, $time);
        end else begin
          check("o_data", 32'(o_data), 32'(exp_q[0]));
          if (i_ready) begin
            rx_log.push_back(o_data);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] e[$];
    logic [7:0] sent[$];
    logic [7:0] b;

    // Reset values while reset is held from time zero.
    #2;
    check("init_o_valid", 32'(o_valid), 32'd0);
    check("init_o_level", 32'(o_level), 32'd0);
    check("init_o_data", 32'(o_data), 32'd0);
    check("init_o_overflow", 32'(o_overflow), 32'd0);
    check("init_o_drop_cnt", 32'(o_drop_cnt), 32'd0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst = 0;
    mon_en = 1;

    // To-upper "aZ{" with latency check on the first byte.
    rx_log.delete();
    step(1, 8'h61, 2'd1, 1, 0);
    check("lat_edge_n", 32'(o_valid), 32'd0);
    step(1, 8'h5A, 2'd1, 1, 0);
    check("lat_edge_n1_valid", 32'(o_valid), 32'd1);
    check("lat_edge_n1_data", 32'(o_data), 32'h41);
    step(1, 8'h7B, 2'd1, 1, 0);
    drain();
    e = {8'h41, 8'h5A, 8'h7B};
    check_log("upper_seq", e);

    // Swap case.
    rx_log.delete();
    step(1, 8'h61, 2'd3, 1, 0);
    step(1, 8'h41, 2'd3, 1, 0);
    step(1, 8'hE1, 2'd3, 1, 0);
    drain();
    e = {8'h41, 8'h61, 8'hE1};
    check_log("swap_seq", e);

    // Pass-through.
    rx_log.delete();
    step(1, 8'h61, 2'd0, 1, 0);
    step(1, 8'h41, 2'd0, 1, 0);
    step(1, 8'h7A, 2'd0, 1, 0);
    step(1, 8'hFF, 2'd0, 1, 0);
    drain();
    e = {8'h61, 8'h41, 8'h7A, 8'hFF};
    check_log("pass_seq", e);

    // Fill to DEPTH, then a 17th byte is dropped.
    rx_log.delete(); sent.delete();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      sent.push_back(b);
      step(1, b, 2'd0, 0, 0);
    end
    step(1, 8'h5C, 2'd0, 0, 0);
    check("full_level", 32'(o_level), 32'(DEPTH));
    check("full_no_ovf", 32'(o_overflow), 32'd0);
    step(0, 8'h00, 2'd0, 0, 0);
    check("drop_ovf", 32'(o_overflow), 32'd1);
    check("drop_cnt", 32'(o_drop_cnt), 32'd1);
    check("drop_level", 32'(o_level), 32'(DEPTH));
    drain();
    check_log("drop_order", sent);
    step(0, 8'h00, 2'd0, 0, 1);
    check("clr_ovf", 32'(o_overflow), 32'd0);

    // Full FIFO with a write and pop on the same edge.
    rx_log.delete(); sent.delete();
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      sent.push_back(b);
      step(1, b, 2'd0, 0, 0);
    end
    check("fp_level_before", 32'(o_level), 32'(DEPTH));
    step(0, 8'h00, 2'd0, 1, 0);
    check("fp_level_after", 32'(o_level), 32'(DEPTH));
    check("fp_no_ovf", 32'(o_overflow), 32'd0);
    drain();
    check_log("fp_order", sent);

    // Reset with bytes buffered, then recovery.
    for (int i = 0; i < 5; i++) step(1, 8'($urandom_range(0, 255)), 2'd2, 0, 0);
    step(0, 8'h00, 2'd0, 0, 0);
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    check("pre_rst_level", 32'(o_level), 32'd5);
    do_reset();
    step(1, 8'h62, 2'd1, 0, 0);
    check("post_rst_lat_n", 32'(o_valid), 32'd0);
    step(0, 8'h00, 2'd1, 0, 0);
    check("post_rst_valid", 32'(o_valid), 32'd1);
    check("post_rst_data", 32'(o_data), 32'h42);
    drain();

    // Randomised traffic with stalls and occasional clears.
    for (int i = 0; i < 800; i++) begin
      step(bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 39) == 0));
    end
    drain();

    // Saturate the drop counter, then clear.
    for (int i = 0; i < 330; i++) step(1, 8'($urandom_range(0, 255)), 2'd0, 0, 0);
    step(0, 8'h00, 2'd0, 0, 0);
    check("sat_cnt", 32'(o_drop_cnt), 32'hFF);
    check("sat_ovf", 32'(o_overflow), 32'd1);
    step(0, 8'h00, 2'd0, 0, 1);
    check("sat_clr_cnt", 32'(o_drop_cnt), 32'd0);
    check("sat_clr_ovf", 32'(o_overflow), 32'd0);
    drain();

    // Clear coincident with a drop: drop wins.
    for (int i = 0; i <= DEPTH; i++) step(1, 8'($urandom_range(0, 255)), 2'd0, 0, 0);
    step(0, 8'h00, 2'd0, 0, 1);
    check("clr_drop_ovf", 32'(o_overflow), 32'd1);
    check("clr_drop_cnt", 32'(o_drop_cnt), 32'd1);
    drain();

    repeat (2) @(posedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
